// File: rtl/level_timed_data_shift_pkg.sv
// Shared defaults and the launch-point helper for the level-timed serial transmitter.
// Pure constants and functions: no latency and no backpressure.
package level_shift_pkg;

  localparam int unsigned LS_HALF_PERIOD = 5;
  localparam int unsigned LS_DATA_WIDTH  = 8;
  localparam logic [LS_DATA_WIDTH-1:0] LS_DATA = 8'hA5;

  // Divider count at which sda is launched: the middle of the sclk-low level.
  function automatic int unsigned ls_launch_idx(input int unsigned half_period);
    return half_period / 2;
  endfunction

endpackage

// File: rtl/level_timed_data_shift_if.sv
// Serial bus bundle (sclk/sda) between the transmitter and its observer.
// Wires only: no latency and no backpressure.
interface level_timed_data_shift_if;

  logic sclk;
  logic sda;

  modport master (output sclk, output sda);
  modport slave  (input  sclk, input  sda);

endinterface

// File: rtl/level_timed_data_shift_sclk_divider.sv
// Divides clk down to sclk and flags the mid-low launch point for sda.
// sclk is registered; launch is decoded from the current divider state. No backpressure.
module sclk_divider
  import level_shift_pkg::*;
#(
  parameter int unsigned HALF_PERIOD = LS_HALF_PERIOD
) (
  input  logic clk,
  input  logic rst_n,
  output logic o_sclk,
  output logic o_launch
);

  localparam int unsigned CW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
  localparam logic [CW-1:0] LAST_CNT   = CW'(HALF_PERIOD - 1);
  localparam logic [CW-1:0] LAUNCH_CNT = CW'(ls_launch_idx(HALF_PERIOD));

  logic [CW-1:0] r_div_cnt;
  logic          r_sclk;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div_cnt <= '0;
      r_sclk    <= 1'b0;
    end else if (r_div_cnt == LAST_CNT) begin
      r_div_cnt <= '0;
      r_sclk    <= ~r_sclk;
    end else begin
      r_div_cnt <= r_div_cnt + CW'(1);
    end
  end

  // Consumed on the same edge by the sda flop, so sda moves one cycle after this state.
  assign o_launch = ~r_sclk && (r_div_cnt == LAUNCH_CNT);
  assign o_sclk   = r_sclk;

endmodule

// File: rtl/level_timed_data_shift.sv
// Free-running serial source: shifts DATA out MSB first on sda, launched mid sclk-low.
// Outputs straight from flops; one bit per 2*HALF_PERIOD clk cycles; no backpressure.
module level_timed_data_shift
  import level_shift_pkg::*;
#(
  parameter int unsigned HALF_PERIOD = LS_HALF_PERIOD,
  parameter int unsigned DATA_WIDTH  = LS_DATA_WIDTH,
  parameter logic [DATA_WIDTH-1:0] DATA = DATA_WIDTH'(LS_DATA)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  level_timed_data_shift_if.master  bus
);

  localparam int unsigned IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [IW-1:0] MSB_IDX = IW'(DATA_WIDTH - 1);

  generate
    if (HALF_PERIOD < 2) begin : g_bad_half_period
      $error("level_timed_data_shift: HALF_PERIOD must be at least 2");
    end
  endgenerate

  logic          w_sclk;
  logic          w_launch;
  logic [IW-1:0] r_bit_idx;
  logic          r_sda;

  sclk_divider #(
    .HALF_PERIOD (HALF_PERIOD)
  ) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .o_sclk   (w_sclk),
    .o_launch (w_launch)
  );

  // sda idles high; words run back to back with no framing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sda     <= 1'b1;
      r_bit_idx <= MSB_IDX;
    end else if (w_launch) begin
      r_sda     <= DATA[r_bit_idx];
      r_bit_idx <= (r_bit_idx == '0) ? MSB_IDX : (r_bit_idx - IW'(1));
    end
  end

  assign bus.sclk = w_sclk;
  assign bus.sda  = r_sda;

endmodule

// File: tb/tb_level_timed_data_shift.sv
// Directed bench for level_timed_data_shift: default, HALF_PERIOD=2 and HALF_PERIOD=7/4-bit instances.
module tb_level_timed_data_shift;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n1, rst_n2, rst_n3;

  level_timed_data_shift_if if1 ();
  level_timed_data_shift_if if2 ();
  level_timed_data_shift_if if3 ();

  level_timed_data_shift dut1 (
    .clk   (clk),
    .rst_n (rst_n1),
    .bus   (if1.master)
  );

  level_timed_data_shift #(
    .HALF_PERIOD (2),
    .DATA_WIDTH  (8),
    .DATA        (8'h81)
  ) dut2 (
    .clk   (clk),
    .rst_n (rst_n2),
    .bus   (if2.master)
  );

  level_timed_data_shift #(
    .HALF_PERIOD (7),
    .DATA_WIDTH  (4),
    .DATA        (4'hC)
  ) dut3 (
    .clk   (clk),
    .rst_n (rst_n3),
    .bus   (if3.master)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    int   edge_n;
    logic sclk;
    logic sda;
  } vec_t;

  localparam int NV = 15;
  vec_t tbl [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Sample 2 ns after the rising edge, well away from it.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  function automatic logic exp_sclk(input int n, input int hp);
    return ((n / hp) % 2) == 1;
  endfunction

  function automatic logic exp_sda(input int n, input int hp, input int w, input logic [7:0] d);
    int first;
    int k;
    first = hp / 2 + 1;
    if (n < first) return 1'b1;
    k = (n - first) / (2 * hp);
    return d[w - 1 - (k % w)];
  endfunction

  // Level-timing monitor: sda must not move while sclk is high, nor (for dut1) on a toggle edge.
  bit   mon1 = 0, mon2 = 0;
  int   viol1_high = 0, viol1_tog = 0, viol2_high = 0;
  logic p1_sclk = 1'b0, p1_sda = 1'b1, p2_sclk = 1'b0, p2_sda = 1'b1;

  always @(posedge clk) begin
    #1;
    if (mon1 && (if1.sda !== p1_sda)) begin
      if (p1_sclk) viol1_high++;
      if (if1.sclk !== p1_sclk) viol1_tog++;
    end
    if (mon2 && (if2.sda !== p2_sda) && p2_sclk) viol2_high++;
    p1_sclk = if1.sclk;
    p1_sda  = if1.sda;
    p2_sclk = if2.sclk;
    p2_sda  = if2.sda;
  end

  initial begin
    tbl[0]  = '{2,  1'b0, 1'b1};
    tbl[1]  = '{3,  1'b0, 1'b1};
    tbl[2]  = '{4,  1'b0, 1'b1};
    tbl[3]  = '{5,  1'b1, 1'b1};
    tbl[4]  = '{10, 1'b0, 1'b1};
    tbl[5]  = '{13, 1'b0, 1'b0};
    tbl[6]  = '{15, 1'b1, 1'b0};
    tbl[7]  = '{23, 1'b0, 1'b1};
    tbl[8]  = '{33, 1'b0, 1'b0};
    tbl[9]  = '{43, 1'b0, 1'b0};
    tbl[10] = '{53, 1'b0, 1'b1};
    tbl[11] = '{63, 1'b0, 1'b0};
    tbl[12] = '{73, 1'b0, 1'b1};
    tbl[13] = '{83, 1'b0, 1'b1};
    tbl[14] = '{85, 1'b1, 1'b1};

    rst_n1 = 1'b0;
    rst_n2 = 1'b0;
    rst_n3 = 1'b0;

    for (int i = 0; i < 5; i++) begin
      step();
      chk("reset_hold_sclk", if1.sclk, 1'b0);
      chk("reset_hold_sda", if1.sda, 1'b1);
    end

    // Default instance: 200 edges against the table and the closed-form model.
    rst_n1 = 1'b1;
    mon1   = 1;
    for (int n = 1; n <= 200; n++) begin
      step();
      chk("dflt_sclk", if1.sclk, exp_sclk(n, 5));
      chk("dflt_sda", if1.sda, exp_sda(n, 5, 8, 8'hA5));
      for (int j = 0; j < NV; j++) begin
        if (tbl[j].edge_n == n) begin
          chk("tbl_sclk", if1.sclk, tbl[j].sclk);
          chk("tbl_sda", if1.sda, tbl[j].sda);
        end
      end
    end
    mon1 = 0;
    chk("sda_moved_while_sclk_high", viol1_high, 0);
    chk("sda_moved_on_sclk_toggle", viol1_tog, 0);

    // Mid-word reset at edge 37 (bit 3 in flight, sclk high).
    rst_n1 = 1'b0;
    step();
    rst_n1 = 1'b1;
    for (int n = 1; n <= 37; n++) step();
    chk("pre_reset_sclk", if1.sclk, 1'b1);
    chk("pre_reset_sda", if1.sda, 1'b0);
    rst_n1 = 1'b0;
    #1;
    chk("async_reset_sclk", if1.sclk, 1'b0);
    chk("async_reset_sda", if1.sda, 1'b1);
    step();
    step();
    rst_n1 = 1'b1;
    for (int n = 1; n <= 45; n++) begin
      step();
      chk("restart_sclk", if1.sclk, exp_sclk(n, 5));
      chk("restart_sda", if1.sda, exp_sda(n, 5, 8, 8'hA5));
    end

    // HALF_PERIOD=2, DATA=8'h81: launch coincides with the rising toggle.
    chk("hp2_reset_sclk", if2.sclk, 1'b0);
    chk("hp2_reset_sda", if2.sda, 1'b1);
    rst_n2 = 1'b1;
    mon2   = 1;
    for (int n = 1; n <= 72; n++) begin
      step();
      chk("hp2_sclk", if2.sclk, exp_sclk(n, 2));
      chk("hp2_sda", if2.sda, exp_sda(n, 2, 8, 8'h81));
    end
    mon2 = 0;
    chk("hp2_sda_moved_while_sclk_high", viol2_high, 0);

    // HALF_PERIOD=7, 4-bit word 4'hC.
    chk("hp7_reset_sclk", if3.sclk, 1'b0);
    chk("hp7_reset_sda", if3.sda, 1'b1);
    rst_n3 = 1'b1;
    for (int n = 1; n <= 130; n++) begin
      step();
      chk("hp7_sclk", if3.sclk, exp_sclk(n, 7));
      chk("hp7_sda", if3.sda, exp_sda(n, 7, 4, 8'h0C));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
